// File: rtl/collision_sequencer.sv
// collision_sequencer
//   Per-frame game-loop controller. On each accepted frame_tick it pulses
//   start_move, waits for the enemy mover, then holds detect_collide until the
//   collision detector answers. It then evaluates the result: lives, the
//   invulnerability window and game over. It is the only driver of
//   detect_collide.
//
// Ports
//   clk            in   system clock
//   reset          in   synchronous, active-low
//   frame_tick     in   one-cycle pulse per video frame
//   space_pressed  in   start/restart request (level)
//   move_done      in   enemy mover finished (one-cycle pulse)
//   detect_done    in   detector done (level while detect_collide high)
//   collide_in     in   detector collide, valid while detect_done=1
//   start_move     out  one-cycle pulse: update enemy positions
//   detect_collide out  level request to the detector
//   hit_pulse      out  one-cycle pulse: a counted hit occurred
//   lives          out  remaining lives (3 bits)
//   invuln         out  invulnerability window active
//   game_over      out  lives reached 0
//   frames_alive   out  frames survived since start, saturating (16 bits)
//   overrun        out  sticky: frame_tick arrived while busy
//   timeout_err    out  sticky: a handshake timed out
module collision_sequencer #(
    parameter int LIVES         = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        space_pressed,
    input  logic        move_done,
    input  logic        detect_done,
    input  logic        collide_in,
    output logic        start_move,
    output logic        detect_collide,
    output logic        hit_pulse,
    output logic [2:0]  lives,
    output logic        invuln,
    output logic        game_over,
    output logic [15:0] frames_alive,
    output logic        overrun,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE, WAIT_TICK, MOVE, DETECT, EVAL, GAME_OVER
    } state_t;

    localparam logic [2:0] LIVES_INIT = 3'(LIVES);
    localparam logic [7:0] INV_INIT   = 8'(INVULN_FRAMES);
    localparam logic [7:0] TMO        = 8'(TIMEOUT);

    state_t     state;
    logic [7:0] wdog;
    logic [7:0] inv_cnt;
    logic       collide_lat;

    logic       restart;
    logic       hit_now;
    logic [2:0] lives_next;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [2:0] lives_dec(input logic [2:0] v);
        return (v == 3'd0) ? 3'd0 : v - 3'd1;
    endfunction

    // space_pressed restarts from every state except WAIT_TICK, where the
    // game is already running and idle between frames.
    always_comb begin
        restart    = space_pressed && (state != WAIT_TICK);
        hit_now    = collide_lat && !invuln && (lives != 3'd0);
        lives_next = hit_now ? lives_dec(lives) : lives;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            start_move     <= 1'b0;
            detect_collide <= 1'b0;
            hit_pulse      <= 1'b0;
            lives          <= LIVES_INIT;
            invuln         <= 1'b0;
            game_over      <= 1'b0;
            frames_alive   <= 16'd0;
            overrun        <= 1'b0;
            timeout_err    <= 1'b0;
            wdog           <= 8'd0;
            inv_cnt        <= 8'd0;
            collide_lat    <= 1'b0;
        end else begin
            start_move <= 1'b0;
            hit_pulse  <= 1'b0;
            if (restart) begin
                // Start, restart after game over, or live restart mid-frame.
                state          <= WAIT_TICK;
                detect_collide <= 1'b0;
                lives          <= LIVES_INIT;
                invuln         <= 1'b0;
                inv_cnt        <= 8'd0;
                game_over      <= 1'b0;
                frames_alive   <= 16'd0;
                overrun        <= 1'b0;
                timeout_err    <= 1'b0;
                wdog           <= 8'd0;
            end else begin
                case (state)
                    WAIT_TICK: begin
                        if (frame_tick) begin
                            state      <= MOVE;
                            start_move <= 1'b1;
                            wdog       <= 8'd0;
                            // The window covers INVULN_FRAMES whole frames:
                            // it only ends on the tick that finds the count
                            // already exhausted.
                            if (invuln) begin
                                if (inv_cnt == 8'd0) invuln <= 1'b0;
                                else inv_cnt <= inv_cnt - 8'd1;
                            end
                        end
                    end
                    MOVE: begin
                        if (frame_tick) overrun <= 1'b1;
                        if (move_done) begin
                            state          <= DETECT;
                            detect_collide <= 1'b1;
                            wdog           <= 8'd0;
                        end else if (wdog == TMO) begin
                            state       <= WAIT_TICK;
                            timeout_err <= 1'b1;
                        end else begin
                            wdog <= wdog + 8'd1;
                        end
                    end
                    DETECT: begin
                        if (frame_tick) overrun <= 1'b1;
                        // wdog==0 marks the first DETECT cycle, where
                        // detect_done may still show the previous answer.
                        if (detect_done && (wdog != 8'd0)) begin
                            collide_lat    <= collide_in;
                            detect_collide <= 1'b0;
                            state          <= EVAL;
                        end else if (wdog == TMO) begin
                            detect_collide <= 1'b0;
                            state          <= WAIT_TICK;
                            timeout_err    <= 1'b1;
                        end else begin
                            wdog <= wdog + 8'd1;
                        end
                    end
                    EVAL: begin
                        if (frame_tick) overrun <= 1'b1;
                        frames_alive <= sat_inc16(frames_alive);
                        if (hit_now) begin
                            hit_pulse <= 1'b1;
                            lives     <= lives_next;
                            invuln    <= (INV_INIT != 8'd0);
                            inv_cnt   <= INV_INIT;
                        end
                        if (lives_next == 3'd0) begin
                            state     <= GAME_OVER;
                            game_over <= 1'b1;
                        end else begin
                            state <= WAIT_TICK;
                        end
                    end
                    IDLE, GAME_OVER: begin
                        // Only space_pressed (handled above) leaves these.
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
